// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side blocks: default word width, word type
// and the holding-buffer occupancy encoding.
package fifo_pkg;

   localparam int FIFO_WIDTH = 8;

   typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry holding buffer: absorbs words arriving one cycle after the read
// request so the consumer can stall without losing data.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output occ_t             occ
);

   occ_t             occ_q;
   occ_t             occ_d;
   logic             head_ptr;
   logic             tail_ptr;
   logic             pop_ok;
   logic             push_ok;
   logic [WIDTH-1:0] mem [2];

   assign pop_ok  = pop & (occ_q != OCC_EMPTY);
   assign push_ok = push & ((occ_q != OCC_TWO) | pop_ok);
   // With one word held the tail is the other slot; when empty or full it
   // coincides with the head slot (the freed entry on a simultaneous pop).
   assign tail_ptr = head_ptr ^ (occ_q == OCC_ONE);

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge value of the others, independent of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= OCC_EMPTY;
      end else begin
         occ_q <= occ_d;
      end
   end

   // NOTE: occ_d takes a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      occ_d = occ_q;
      if (push_ok && !pop_ok) begin
         if (occ_q == OCC_EMPTY) occ_d = OCC_ONE;
         else                    occ_d = OCC_TWO;
      end else if (pop_ok && !push_ok) begin
         if (occ_q == OCC_TWO)   occ_d = OCC_ONE;
         else                    occ_d = OCC_EMPTY;
      end
   end

   // NOTE: the storage entries are reset too, so the head reads as zero out
   // of reset rather than X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr <= 1'b0;
         mem[0]   <= '0;
         mem[1]   <= '0;
      end else begin
         if (push_ok) mem[tail_ptr] <= push_data;
         if (pop_ok)  head_ptr      <= ~head_ptr;
      end
   end

   always_comb begin
      head = mem[head_ptr];
      occ  = occ_q;
   end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: issues FIFO reads against a two-word credit and
// presents the buffered words as a valid/ready stream.
module fifo_rd_ctrl #(
   parameter int FIFO_WIDTH  = fifo_pkg::FIFO_WIDTH,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   enable,
   input  logic                   fifo_empty,
   output logic                   fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0]  fifo_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [FIFO_WIDTH-1:0]  m_data,
   output logic [COUNT_WIDTH-1:0] rd_count,
   output logic                   idle
);
   import fifo_pkg::*;

   occ_t       occ;
   logic [1:0] occ_bits;
   logic [2:0] level;
   logic       inflight;
   logic       pop;
   logic       credit;

   assign occ_bits = occ;
   assign pop      = m_valid & m_ready;
   // Words already owed to the buffer; a pop this cycle frees one slot early,
   // which is what sustains one word per cycle.
   assign level    = {1'b0, occ_bits} + {2'b00, inflight};
   assign credit   = level < (3'd2 + {2'b00, pop});

   assign fifo_rd_en = enable & ~fifo_empty & credit;
   assign m_valid    = (occ != OCC_EMPTY);
   assign idle       = (occ == OCC_EMPTY) & ~inflight;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         inflight <= 1'b0;
         rd_count <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (pop) rd_count <= rd_count + 1'b1;
      end
   end

   fifo_rd_skid #(
      .WIDTH (FIFO_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rstN),
      .push      (inflight),
      .push_data (fifo_data),
      .pop       (pop),
      .head      (m_data),
      .occ       (occ)
   );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a queue-based FIFO model feeds the DUT,
// a negedge monitor compares the stream against the written word order.
module tb_fifo_rd_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        m_ready = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_data = 8'h00;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_data = 8'h00;

   logic        rd_en, m_valid, idle;
   logic [7:0]  m_data;
   logic [15:0] rd_count;
   logic        rd_en_w, m_valid_w, idle_w;
   logic [7:0]  m_data_w;
   logic [3:0]  rd_count_w;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] q[$];
   logic [7:0] exp_q[$];

   int outst = 0;
   int pops  = 0;
   int rd_pulses = 0;
   logic held = 1'b0;
   logic [7:0] held_data = 8'h00;

   always #5 clk = ~clk;

   fifo_rd_ctrl #(.FIFO_WIDTH(8), .COUNT_WIDTH(16)) dut (
      .clk(clk), .rstN(rst_n), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rd_en(rd_en), .fifo_data(fifo_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .rd_count(rd_count), .idle(idle)
   );

   fifo_rd_ctrl #(.FIFO_WIDTH(8), .COUNT_WIDTH(4)) dut_w4 (
      .clk(clk), .rstN(rst_n), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rd_en(rd_en_w), .fifo_data(fifo_data), .m_valid(m_valid_w),
      .m_ready(m_ready), .m_data(m_data_w), .rd_count(rd_count_w), .idle(idle_w)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous FIFO model: registered read data, empty updated at the edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         exp_q.delete();
         fifo_data  <= 8'h00;
         fifo_empty <= 1'b1;
      end else begin
         if (rd_en && q.size() > 0) fifo_data <= q.pop_front();
         if (wr_en) begin
            q.push_back(wr_data);
            exp_q.push_back(wr_data);
         end
         fifo_empty <= (q.size() == 0);
      end
   end

   // Monitor: outst = reads issued minus words delivered.
   always @(negedge clk) begin
      logic       p;
      logic [7:0] e;
      if (!rst_n) begin
         outst = 0;
         pops  = 0;
         held  = 1'b0;
      end else begin
         p = m_valid & m_ready;
         check("idle", idle, outst == 0);
         check("idle_w4", idle_w, outst == 0);
         check("rd_en_rule", rd_en, enable && !fifo_empty && (outst - int'(p)) < 2);
         check("rd_en_rule_w4", rd_en_w, enable && !fifo_empty && (outst - int'(p)) < 2);
         if (held) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, held_data);
         end
         if (p) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL extra_word: got 0x%0h with nothing expected at %0t", m_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("data", m_data, e);
               check("data_w4", m_data_w, e);
            end
         end
         check("rd_count", rd_count, pops & 32'hFFFF);
         check("rd_count_w4", rd_count_w, pops & 32'hF);
         if (rd_en) rd_pulses++;
         outst = outst + int'(rd_en) - int'(p);
         pops  = pops + int'(p);
         check("outstanding_le2", outst <= 2, 1);
         held      = m_valid && !m_ready;
         held_data = m_data;
      end
   end

   task automatic write_words(input logic [7:0] first, input int n, input logic [7:0] step);
      logic [7:0] w;
      w = first;
      for (int i = 0; i < n; i++) begin
         @(posedge clk) #1;
         wr_en   = 1'b1;
         wr_data = w;
         w       = w + step;
      end
      @(posedge clk) #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         ok = idle && fifo_empty && (exp_q.size() == 0) && !wr_en;
      end
      check(name, ok, 1);
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk) #1;
      rst_n = 1'b0;
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_m_data", m_data, 0);
      check("rst_rd_count", rd_count, 0);
      check("rst_idle", idle, 1);
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int k;
      int p0;
      logic seen;

      // Reset state
      #2;
      check("init_m_valid", m_valid, 0);
      check("init_rd_en", rd_en, 0);
      check("init_rd_count", rd_count, 0);
      check("init_idle", idle, 1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic drain with latency measurement
      enable  = 1'b1;
      m_ready = 1'b1;
      fork
         write_words(8'h11, 3, 8'h11);
         begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
               @(negedge clk);
               seen = rd_en;
            end
            check("first_rd_en_seen", seen, 1);
            k = 0;
            while (!m_valid && k < 6) begin
               @(negedge clk);
               k++;
            end
            check("latency_rd_to_valid", k, 2);
            @(negedge clk);
            check("drain_consec_1", m_valid, 1);
            @(negedge clk);
            check("drain_consec_2", m_valid, 1);
         end
      join
      wait_idle("drain_basic_done", 50);
      check("drain_rd_count", rd_count, 3);
      check("drain_idle", idle, 1);

      // Backpressure: two reads issued, head word held
      m_ready = 1'b0;
      rd_pulses = 0;
      fork
         write_words(8'h00, 10, 8'h01);
         repeat (14) @(negedge clk);
      join
      check("bp_rd_pulses", rd_pulses, 2);
      check("bp_valid", m_valid, 1);
      check("bp_head", m_data, 8'h00);
      @(posedge clk) #1;
      m_ready = 1'b1;
      wait_idle("bp_drain_done", 100);
      check("bp_rd_count", rd_count, 13);

      // Enable dropped one cycle after the first read
      enable = 1'b0;
      write_words(8'hA0, 5, 8'h01);
      p0 = pops;
      @(posedge clk) #1;
      enable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = rd_en;
      end
      check("en_first_rd", seen, 1);
      @(posedge clk) #1;
      enable = 1'b0;
      rd_pulses = 0;
      repeat (10) @(negedge clk);
      check("en_no_more_reads", rd_pulses, 0);
      check("en_inflight_delivered", pops - p0, 1);
      @(posedge clk) #1;
      enable = 1'b1;
      wait_idle("en_drain_done", 100);

      // Reset mid-burst discards buffered and in-flight words
      m_ready = 1'b0;
      write_words(8'h50, 5, 8'h01);
      repeat (2) @(posedge clk);
      do_reset(2);
      repeat (2) @(negedge clk);
      check("post_rst_idle", idle, 1);

      // Counter wrap on the 4-bit instance
      m_ready = 1'b1;
      write_words(8'h30, 17, 8'h01);
      wait_idle("wrap_drain_done", 200);
      check("wrap_rd_count_w4", rd_count_w, 1);
      check("wrap_rd_count", rd_count, 17);

      // Random traffic: 256 words, 50% ready, random refill
      p0 = pops;
      k  = 0;
      for (int c = 0; c < 5000 && k < 256; c++) begin
         @(posedge clk) #1;
         wr_en = (k < 256) && ($urandom_range(0, 1) == 1);
         if (wr_en) begin
            wr_data = 8'($urandom);
            k++;
         end
         m_ready = ($urandom_range(0, 1) == 1);
      end
      @(posedge clk) #1;
      wr_en   = 1'b0;
      m_ready = 1'b1;
      check("rand_all_written", k, 256);
      wait_idle("rand_drain_done", 1000);
      check("rand_delivered", pops - p0, 256);
      check("rand_rd_count", rd_count, 17 + 256);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
